// File: rtl/apb_slave_regbank.sv
// Parametrised APB slave register bank with wait states,
// byte strobes and error response for bad addresses.
module apb_slave_regbank #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSELx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    m_ready,
  output logic                    m_error
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = ADDR_WIDTH - OFF;
  localparam int RW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);
  localparam logic [3:0]  WS_W    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    wr_q;
  logic                    err_q;
  logic [IW-1:0]           idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NB-1:0]           strb_q;
  logic [DATA_WIDTH-1:0]   regs_q [DEPTH];

  logic [IW-1:0] idx;
  logic          unal;
  logic          oor;
  logic          err;
  logic          ready;
  logic          we;
  logic [RW-1:0] ridx;

  assign idx = PADDR[ADDR_WIDTH-1:OFF];

  generate
    if (OFF == 0) begin : g_byte
      assign unal = 1'b0;
    end else begin : g_wide
      assign unal = |PADDR[OFF-1:0];
    end
  endgenerate

  assign oor   = {1'b0, idx} >= DEPTH_W;
  assign err   = unal | oor;
  assign ready = (state_q == ACCESS) && (cnt_q == WS_W);
  assign we    = ready & wr_q & ~err_q;
  assign ridx  = idx_q[RW-1:0];

  assign m_ready = ready;
  assign m_error = ready & err_q;
  assign m_rdata = (ready && !wr_q && !err_q) ? regs_q[ridx] : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (PSELx && !PENABLE) state_q <= SETUP;
        end
        SETUP: begin
          wr_q    <= PWRITE;
          err_q   <= err;
          idx_q   <= idx;
          wdata_q <= PWDATA;
          strb_q  <= PSTRB;
          cnt_q   <= '0;
          state_q <= (PSELx && PENABLE) ? ACCESS : IDLE;
        end
        ACCESS: begin
          if (ready) begin
            state_q <= (PSELx && !PENABLE) ? SETUP : IDLE;
          end else if (!PSELx) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Commit on the edge that closes the ready cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) regs_q[ridx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Self-checking bench for apb_slave_regbank: vector table,
// response scoreboard and multi-cycle corner sequences.
module tb_apb_slave_regbank;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [2:0]  sel = 3'b000;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;

  logic [31:0] rd0, rd2;
  logic [7:0]  rd1;
  logic [2:0]  rdy_v;
  logic [2:0]  err_v;
  logic [31:0] rd_v [3];

  always #5 PCLK = ~PCLK;

  apb_slave_regbank #(.ADDR_WIDTH(8), .DATA_WIDTH(32),
    .DEPTH(16), .WAIT_STATES(2)) u_ws2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(sel[0]),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .m_rdata(rd0), .m_ready(rdy_v[0]), .m_error(err_v[0]));

  apb_slave_regbank #(.ADDR_WIDTH(8), .DATA_WIDTH(8),
    .DEPTH(16), .WAIT_STATES(1)) u_dw8 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(sel[1]),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA[7:0]), .PSTRB(PSTRB[0:0]),
    .m_rdata(rd1), .m_ready(rdy_v[1]), .m_error(err_v[1]));

  apb_slave_regbank #(.ADDR_WIDTH(8), .DATA_WIDTH(32),
    .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(sel[2]),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB),
    .m_rdata(rd2), .m_ready(rdy_v[2]), .m_error(err_v[2]));

  assign rd_v[0] = rd0;
  assign rd_v[1] = {24'h0, rd1};
  assign rd_v[2] = rd2;

  typedef struct {
    int          tgt;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    bit          err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   cur = 0;
  int   vecs = 0;
  int   errs = 0;

  function automatic int ws_of(input int t);
    return (t == 0) ? 2 : (t == 1) ? 1 : 0;
  endfunction

  always @(negedge PCLK) begin
    if (PRESETn && rdy_v[cur]) begin
      exp_t e;
      vecs++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_ready dut%0d: got ready=1 want no response", cur);
      end else begin
        e = sb.pop_front();
        if (rd_v[cur] !== e.rdata || err_v[cur] !== e.err) begin
          errs++;
          $display("FAIL resp dut%0d: got rdata=%h err=%b want rdata=%h err=%b",
                   cur, rd_v[cur], err_v[cur], e.rdata, e.err);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic idle_bus();
    sel = 3'b000;
    PENABLE = 1'b0;
    PWRITE = 1'b0;
  endtask

  task automatic xfer(input int t, input bit w, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] er, input bit ee);
    int n;
    cur = t;
    sb.push_back('{er, ee});
    sel = 3'b000;
    sel[t] = 1'b1;
    PENABLE = 1'b0;
    PWRITE = w;
    PADDR = a;
    PWDATA = d;
    PSTRB = s;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    forever begin
      @(negedge PCLK);
      if (rdy_v[t]) break;
      n++;
      if (n > 40) break;
    end
    if (n > 40) sb.delete();
    chk($sformatf("latency dut%0d a=%h", t, a), n, ws_of(t) + 1);
    @(posedge PCLK); #1;
    idle_bus();
  endtask

  task automatic chk_rdy(input string nm, input bit want);
    @(negedge PCLK);
    chk(nm, {31'h0, rdy_v[cur]}, {31'h0, want});
  endtask

  initial begin
    int quiet;
    vt.push_back('{0, 1, 8'h04, 32'hDEADBEEF, 4'hF, 32'h0, 0});
    vt.push_back('{0, 0, 8'h04, 32'h0, 4'h0, 32'hDEADBEEF, 0});
    vt.push_back('{0, 1, 8'h04, 32'h0000AA00, 4'b0010, 32'h0, 0});
    vt.push_back('{0, 0, 8'h04, 32'h0, 4'h0, 32'hDEADAAEF, 0});
    vt.push_back('{0, 1, 8'h40, 32'h12345678, 4'hF, 32'h0, 1});
    vt.push_back('{0, 0, 8'h40, 32'h0, 4'h0, 32'h0, 1});
    vt.push_back('{0, 1, 8'h05, 32'hAAAAAAAA, 4'hF, 32'h0, 1});
    vt.push_back('{0, 0, 8'h04, 32'h0, 4'h0, 32'hDEADAAEF, 0});
    vt.push_back('{0, 1, 8'h3C, 32'hCAFEF00D, 4'hF, 32'h0, 0});
    vt.push_back('{0, 1, 8'h3C, 32'hFFFFFFFF, 4'h0, 32'h0, 0});
    vt.push_back('{0, 0, 8'h3C, 32'h0, 4'h0, 32'hCAFEF00D, 0});
    vt.push_back('{0, 0, 8'h00, 32'h0, 4'h0, 32'h0, 0});
    vt.push_back('{0, 0, 8'h06, 32'h0, 4'h0, 32'h0, 1});
    vt.push_back('{1, 1, 8'h05, 32'h0000005A, 4'h1, 32'h0, 0});
    vt.push_back('{1, 0, 8'h05, 32'h0, 4'h0, 32'h5A, 0});
    vt.push_back('{1, 1, 8'h10, 32'h000000C3, 4'h1, 32'h0, 1});
    vt.push_back('{1, 0, 8'h10, 32'h0, 4'h0, 32'h0, 1});
    vt.push_back('{1, 0, 8'h0F, 32'h0, 4'h0, 32'h0, 0});

    #12;
    for (int t = 0; t < 3; t++) begin
      chk($sformatf("reset ready dut%0d", t), {31'h0, rdy_v[t]}, 32'h0);
      chk($sformatf("reset error dut%0d", t), {31'h0, err_v[t]}, 32'h0);
      chk($sformatf("reset rdata dut%0d", t), rd_v[t], 32'h0);
    end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    foreach (vt[i]) begin
      xfer(vt[i].tgt, vt[i].wr, vt[i].addr, vt[i].wdata,
           vt[i].strb, vt[i].rdata, vt[i].err);
    end

    cur = 0;
    sel = 3'b001; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 8'h0C; PWDATA = 32'h11112222; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    sel = 3'b000;
    @(posedge PCLK); #1;
    sel = 3'b001; PENABLE = 1'b0; PADDR = 8'h10;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    sel = 3'b000;
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      if (rdy_v[0]) quiet++;
    end
    chk("abort ready count", quiet, 0);
    @(posedge PCLK); #1;
    idle_bus();
    xfer(0, 0, 8'h0C, 32'h0, 4'h0, 32'h0, 0);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, 32'h0, 0);

    cur = 0;
    sel = 3'b001; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 8'h08; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #1;
    chk("midreset ready", {31'h0, rdy_v[0]}, 32'h0);
    chk("midreset error", {31'h0, err_v[0]}, 32'h0);
    chk("midreset rdata", rd_v[0], 32'h0);
    idle_bus();
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(0, 0, 8'h08, 32'h0, 4'h0, 32'h0, 0);
    xfer(0, 0, 8'h04, 32'h0, 4'h0, 32'h0, 0);
    xfer(1, 0, 8'h05, 32'h0, 4'h0, 32'h0, 0);

    cur = 2;
    sb.push_back('{32'h0, 0});
    sb.push_back('{32'h00000011, 0});
    sb.push_back('{32'h0, 0});
    sel = 3'b100; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 8'h00; PWDATA = 32'h00000011; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    chk_rdy("b2b c2", 1'b0);
    @(posedge PCLK); #1;
    PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00;
    chk_rdy("b2b c3", 1'b1);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    chk_rdy("b2b c4", 1'b0);
    @(posedge PCLK); #1;
    PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 8'h3C; PWDATA = 32'hA5A50F0F;
    chk_rdy("b2b c5", 1'b1);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    chk_rdy("b2b c6", 1'b0);
    @(posedge PCLK); #1;
    idle_bus();
    chk_rdy("b2b c7", 1'b1);
    @(posedge PCLK); #1;
    chk_rdy("b2b c8", 1'b0);
    @(posedge PCLK); #1;
    chk("b2b scoreboard drained", sb.size(), 0);
    sb.delete();
    xfer(2, 0, 8'h3C, 32'h0, 4'h0, 32'hA5A50F0F, 0);
    xfer(2, 0, 8'h00, 32'h0, 4'h0, 32'h00000011, 0);

    repeat (2) @(posedge PCLK);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
